regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (we/wa/wd) between two writers.
- Requester A: pipeline writeback, normal priority, no back-pressure in normal operation.
- Requester B: long-latency unit (mul/div, load return), valid/ready handshake, queued in a small FIFO.
- Drives the RegFile write port from registered outputs and tells the hazard unit which registers have writes still pending.

---
 rtl/regfile_wb_arbiter.sv | 146 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback (A) and a queued long-latency writer (B).
// Optional macro REGFILE_WB_ARB_STATS_EN adds the conflict_cnt statistics output.
module regfile_wb_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_we,
    input  logic [4:0]  a_wa,
    input  logic [31:0] a_wd,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_wa,
    input  logic [31:0] b_wd,
    output logic        a_stall,
    input  logic [4:0]  chk_ra1,
    input  logic [4:0]  chk_ra2,
    output logic        chk_hit1,
    output logic        chk_hit2,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd
`ifdef REGFILE_WB_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] conflict_cnt
`endif
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic {NORMAL, DRAIN} state_t;

    state_t             state_reg, state_next;
    logic [4:0]         q_wa [DEPTH];
    logic [31:0]        q_wd [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [OCC_W-1:0]   count_reg;
    logic [WAIT_W-1:0]  wait_reg, wait_next;
    logic               q_ready, q_nonempty, a_req, push, pop, sel_a;
    logic [DEPTH-1:0]   ent_vld, ent_hit1, ent_hit2;

    // Readiness comes only from registered occupancy, never from a same-cycle pop.
    assign q_ready    = count_reg < OCC_W'(DEPTH);
    assign q_nonempty = count_reg != '0;
    assign b_ready    = rst_n && q_ready;
    assign a_stall    = (state_reg == DRAIN);

    always_comb begin
        a_req      = a_we && (a_wa != 5'd0);
        push       = b_valid && q_ready && (b_wa != 5'd0);
        sel_a      = 1'b0;
        pop        = 1'b0;
        state_next = state_reg;
        wait_next  = wait_reg;

        if (state_reg == NORMAL && a_req) begin
            sel_a = 1'b1;
        end else begin
            pop = q_nonempty;
        end

        if (pop || !q_nonempty) begin
            wait_next = '0;
        end else if (wait_reg != WAIT_W'(MAX_WAIT)) begin
            wait_next = wait_reg + WAIT_W'(1);
        end

        // Entering DRAIN on the same edge the counter saturates gives A exactly MAX_WAIT wins.
        case (state_reg)
            NORMAL:  if (wait_next == WAIT_W'(MAX_WAIT)) state_next = DRAIN;
            DRAIN:   if (pop) state_next = NORMAL;
            default: state_next = NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= NORMAL;
            wait_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            rf_we      <= 1'b0;
            rf_wa      <= 5'd0;
            rf_wd      <= 32'd0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + OCC_W'(1);
                2'b01:   count_reg <= count_reg - OCC_W'(1);
                default: count_reg <= count_reg;
            endcase
            rf_we <= sel_a || pop;
            if (sel_a) begin
                rf_wa <= a_wa;
                rf_wd <= a_wd;
            end else if (pop) begin
                rf_wa <= q_wa[rd_ptr_reg];
                rf_wd <= q_wd[rd_ptr_reg];
            end else begin
                rf_wa <= 5'd0;
                rf_wd <= 32'd0;
            end
        end
    end

    // Queue storage needs no reset; validity is derived from the pointers and occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            q_wa[wr_ptr_reg] <= b_wa;
            q_wd[wr_ptr_reg] <= b_wd;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
        logic [PTR_W-1:0] ofs;
        assign ofs          = PTR_W'(gi) - rd_ptr_reg;
        assign ent_vld[gi]  = {1'b0, ofs} < count_reg;
        assign ent_hit1[gi] = ent_vld[gi] && (q_wa[gi] == chk_ra1);
        assign ent_hit2[gi] = ent_vld[gi] && (q_wa[gi] == chk_ra2);
    end

    assign chk_hit1 = (chk_ra1 != 5'd0) && ((rf_we && rf_wa == chk_ra1) || (|ent_hit1));
    assign chk_hit2 = (chk_ra2 != 5'd0) && ((rf_we && rf_wa == chk_ra2) || (|ent_hit2));

`ifdef REGFILE_WB_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (sel_a && q_nonempty && conflict_cnt != '1) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end
`else
    logic stats_unused;
    assign stats_unused = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based behavioural model.
module tb_regfile_wb_arbiter;
    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;
    localparam int CNT_W    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_we = 1'b0;
    logic [4:0]  a_wa = 5'd0;
    logic [31:0] a_wd = 32'd0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_wa = 5'd0;
    logic [31:0] b_wd = 32'd0;
    logic        a_stall;
    logic [4:0]  chk_ra1 = 5'd0;
    logic [4:0]  chk_ra2 = 5'd0;
    logic        chk_hit1, chk_hit2;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
`ifdef REGFILE_WB_ARB_STATS_EN
    logic [CNT_W-1:0] conflict_cnt;
`endif

    regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_we(a_we), .a_wa(a_wa), .a_wd(a_wd),
        .b_valid(b_valid), .b_ready(b_ready), .b_wa(b_wa), .b_wd(b_wd),
        .a_stall(a_stall),
        .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .chk_hit1(chk_hit1), .chk_hit2(chk_hit2),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
`ifdef REGFILE_WB_ARB_STATS_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;
    bit verbose = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Behavioural model: a plain FIFO of pending B writes, a count of unserved cycles and a drain flag.
    typedef struct packed { logic [4:0] wa; logic [31:0] wd; } ent_t;
    ent_t        mq[$];
    int          m_wait = 0;
    bit          m_drain = 1'b0;
    logic        m_rf_we = 1'b0;
    logic [4:0]  m_rf_wa = 5'd0;
    logic [31:0] m_rf_wd = 32'd0;
    int unsigned m_conf = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_wait  = 0;
            m_drain = 1'b0;
            m_rf_we = 1'b0;
            m_rf_wa = 5'd0;
            m_rf_wd = 32'd0;
            m_conf  = 0;
        end else begin
            bit   had, popped, rdy, a_win;
            ent_t e;
            had    = (mq.size() != 0);
            rdy    = (mq.size() < DEPTH);
            popped = 1'b0;
            a_win  = !m_drain && a_we && (a_wa != 5'd0);
            if (a_win) begin
                m_rf_we = 1'b1; m_rf_wa = a_wa; m_rf_wd = a_wd;
                if (had && m_conf != (2**CNT_W - 1)) m_conf++;
                if (verbose) $display("WB  src=A wa=%0d wd=0x%08h t=%0t", a_wa, a_wd, $time);
            end else if (had) begin
                e = mq.pop_front();
                popped = 1'b1;
                m_rf_we = 1'b1; m_rf_wa = e.wa; m_rf_wd = e.wd;
                if (verbose) $display("WB  src=B wa=%0d wd=0x%08h t=%0t", e.wa, e.wd, $time);
            end else begin
                m_rf_we = 1'b0; m_rf_wa = 5'd0; m_rf_wd = 32'd0;
            end
            if (b_valid && rdy && b_wa != 5'd0) mq.push_back('{wa: b_wa, wd: b_wd});
            if (popped || !had) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait++;
            if (m_drain) begin
                if (popped) m_drain = 1'b0;
            end else if (m_wait == MAX_WAIT) begin
                m_drain = 1'b1;
            end
        end
    end

    function automatic bit exp_hit(input logic [4:0] ra);
        if (ra == 5'd0) return 1'b0;
        if (m_rf_we && m_rf_wa == ra) return 1'b1;
        foreach (mq[i]) if (mq[i].wa == ra) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("b_ready", 32'(b_ready), 32'(rst_n && (mq.size() < DEPTH)));
            check("a_stall", 32'(a_stall), 32'(m_drain));
            check("rf_we", 32'(rf_we), 32'(m_rf_we));
            if (m_rf_we) begin
                check("rf_wa", 32'(rf_wa), 32'(m_rf_wa));
                check("rf_wd", rf_wd, m_rf_wd);
            end
            check("chk_hit1", 32'(chk_hit1), 32'(exp_hit(chk_ra1)));
            check("chk_hit2", 32'(chk_hit2), 32'(exp_hit(chk_ra2)));
`ifdef REGFILE_WB_ARB_STATS_EN
            check("conflict_cnt", 32'(conflict_cnt), m_conf);
`endif
        end
    end

    initial begin
        // Reset state
        chk_ra1 = 5'd5;
        tick(); tick();
        cmp_en = 1'b1;
        check("rst_rf_we", 32'(rf_we), 0);
        check("rst_rf_wa", 32'(rf_wa), 0);
        check("rst_rf_wd", rf_wd, 0);
        check("rst_a_stall", 32'(a_stall), 0);
        check("rst_b_ready", 32'(b_ready), 0);
        check("rst_hit1", 32'(chk_hit1), 0);
        rst_n = 1'b1;
        #1;
        check("rel_b_ready", 32'(b_ready), 1);

        // A-only path, then the same request to r0
        a_we = 1'b1; a_wa = 5'd5; a_wd = 32'hDEADBEEF;
        tick();
        a_we = 1'b0;
        check("a_rf_we", 32'(rf_we), 1);
        check("a_rf_wa", 32'(rf_wa), 5);
        check("a_rf_wd", rf_wd, 32'hDEADBEEF);
        a_we = 1'b1; a_wa = 5'd0;
        tick();
        a_we = 1'b0;
        check("a_r0_rf_we", 32'(rf_we), 0);

        // B minimum latency with A idle: nothing on the first edge, write on the second
        b_valid = 1'b1; b_wa = 5'd6; b_wd = 32'h66;
        tick();
        b_valid = 1'b0;
        check("b_lat_edge1_we", 32'(rf_we), 0);
        tick();
        check("b_lat_edge2_we", 32'(rf_we), 1);
        check("b_lat_edge2_wa", 32'(rf_wa), 6);

        // Fill the queue while A holds the port, then drain in order
        a_we = 1'b1; a_wa = 5'd9; a_wd = 32'h99;
        for (int i = 1; i <= 4; i++) begin
            b_valid = 1'b1; b_wa = 5'(i); b_wd = 32'h11 * i;
            tick();
        end
        b_valid = 1'b0; a_we = 1'b0;
        check("fill_b_ready_low", 32'(b_ready), 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("drain_wa", 32'(rf_wa), i);
            check("drain_wd", rf_wd, 32'h11 * i);
            if (i == 1) check("drain_b_ready_back", 32'(b_ready), 1);
        end
        tick();
        check("drain_idle_we", 32'(rf_we), 0);

        // Starvation: one B entry behind continuous A traffic
        a_we = 1'b1; a_wa = 5'd10; a_wd = 32'hA0A0;
        b_valid = 1'b1; b_wa = 5'd3; b_wd = 32'h33;
        tick();
        b_valid = 1'b0;
        for (int i = 1; i <= MAX_WAIT; i++) begin
            tick();
            check("starve_a_wins", 32'(rf_wa), 10);
            check("starve_stall", 32'(a_stall), (i == MAX_WAIT) ? 1 : 0);
        end
        a_we = 1'b0;
        tick();
        check("starve_b_we", 32'(rf_we), 1);
        check("starve_b_wa", 32'(rf_wa), 3);
        check("starve_b_wd", rf_wd, 32'h33);
        check("starve_stall_clear", 32'(a_stall), 0);

        // Hazard check on a queued destination and on the landing write
        a_we = 1'b1; a_wa = 5'd12; a_wd = 32'hC;
        b_valid = 1'b1; b_wa = 5'd7; b_wd = 32'h77;
        chk_ra1 = 5'd7; chk_ra2 = 5'd0;
        tick();
        b_valid = 1'b0; a_we = 1'b0;
        check("haz_queued_hit1", 32'(chk_hit1), 1);
        check("haz_r0_hit2", 32'(chk_hit2), 0);
        tick();
        check("haz_landing_wa", 32'(rf_wa), 7);
        check("haz_landing_hit1", 32'(chk_hit1), 1);
        tick();
        check("haz_done_hit1", 32'(chk_hit1), 0);

        // Reset with three entries pending
        a_we = 1'b1; a_wa = 5'd13; a_wd = 32'hD;
        chk_ra1 = 5'd8;
        for (int i = 0; i < 3; i++) begin
            b_valid = 1'b1; b_wa = 5'(7 + i); b_wd = 32'h70 + i;
            tick();
        end
        b_valid = 1'b0; a_we = 1'b0;
        check("mid_pending_hit1", 32'(chk_hit1), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rf_we", 32'(rf_we), 0);
        check("mid_rst_b_ready", 32'(b_ready), 0);
        check("mid_rst_hit1", 32'(chk_hit1), 0);
        rst_n = 1'b1;
        tick();
        check("mid_after_rf_we", 32'(rf_we), 0);
        check("mid_after_hit1", 32'(chk_hit1), 0);
        check("mid_after_b_ready", 32'(b_ready), 1);

        // Randomized traffic with varying A pressure
        verbose = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int unsigned pa;
            pa = ((cyc / 200) % 3 == 0) ? 95 : (((cyc / 200) % 3 == 1) ? 40 : 10);
            if (a_stall) a_we = ($urandom_range(0, 9) == 0);
            else         a_we = ($urandom_range(0, 99) < pa);
            a_wa    = 5'($urandom_range(0, 7));
            a_wd    = $urandom;
            b_valid = 1'($urandom_range(0, 1));
            b_wa    = 5'($urandom_range(0, 7));
            b_wd    = $urandom;
            chk_ra1 = 5'($urandom_range(0, 7));
            chk_ra2 = 5'($urandom_range(0, 7));
            if (cyc == 1500) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
